// File: rtl/vga_line_buf.sv
// Ping-pong line buffer feeding the VGA timing controller: one bank fills from the
// pixel stream while the other drains one pixel per request. Optional: VGA_LINE_BUF_TESTPAT_EN.
module vga_line_buf #(
  parameter int          MAX_LINE      = 1024,
  parameter int          AW            = 10,
  parameter logic [11:0] UNDERFLOW_RGB = 12'h000,
  parameter int          BAR_SHIFT     = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] line_len_i,
  input  logic          frame_start_i,
  input  logic          pix_valid_i,
  input  logic [11:0]   pix_data_i,
  output logic          pix_ready_o,
  input  logic          data_req_i,
  output logic [11:0]   data_o,
  output logic [1:0]    bank_full_o,
  output logic          underflow_o,
  input  logic          underflow_clr_i
`ifdef VGA_LINE_BUF_TESTPAT_EN
  ,
  input  logic          test_mode_i
`endif
);

  localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  logic [11:0]   bank0_mem_r [MAX_LINE];
  logic [11:0]   bank1_mem_r [MAX_LINE];

  logic [1:0]    bank_full_r;
  logic          wr_sel_r;
  logic          rd_sel_r;
  logic [AW-1:0] wr_cnt_r;
  logic [AW-1:0] rd_cnt_r;
  logic          rd_active_r;
  logic [11:0]   data_r;
  logic          underflow_r;

  logic [1:0]    bank_full_nxt_s;
  logic          wr_sel_nxt_s;
  logic          rd_sel_nxt_s;
  logic [AW-1:0] wr_cnt_nxt_s;
  logic [AW-1:0] rd_cnt_nxt_s;
  logic          rd_active_nxt_s;
  logic [11:0]   data_nxt_s;
  logic          underflow_nxt_s;
  logic          underflow_set_s;

  logic          test_mode_s;
  logic          pix_ready_s;
  logic          wr_fire_s;
  logic [AW-1:0] line_last_s;
  logic          wr_last_s;
  logic          rd_last_s;
  logic          rd_cur_active_s;
  logic [11:0]   rd_pix_s;
  logic [2:0]    bar_k_s;
  logic [11:0]   bar_pix_s;

`ifdef VGA_LINE_BUF_TESTPAT_EN
  assign test_mode_s = test_mode_i;
`else
  assign test_mode_s = 1'b0;
`endif

  // A transfer needs an EMPTY write bank; anything offered during a flush is dropped.
  assign pix_ready_s     = ~bank_full_r[wr_sel_r] & ~reset;
  assign wr_fire_s       = pix_valid_i & pix_ready_s & ~frame_start_i;
  assign line_last_s     = line_len_i - CNT_ONE;
  assign wr_last_s       = (wr_cnt_r == line_last_s);
  assign rd_last_s       = (rd_cnt_r == line_last_s);
  // A bank filling mid-line is ignored until the next line start.
  assign rd_cur_active_s = (rd_cnt_r == CNT_ZERO) ? bank_full_r[rd_sel_r] : rd_active_r;
  assign rd_pix_s        = rd_sel_r ? bank1_mem_r[rd_cnt_r] : bank0_mem_r[rd_cnt_r];
  assign bar_k_s         = rd_cnt_r[BAR_SHIFT+2:BAR_SHIFT];
  assign bar_pix_s       = {{4{bar_k_s[2]}}, {4{bar_k_s[1]}}, {4{bar_k_s[0]}}};

  // Next-state computation for the bank bookkeeping and the output pixel.
  always_comb begin
    bank_full_nxt_s = bank_full_r;
    wr_sel_nxt_s    = wr_sel_r;
    rd_sel_nxt_s    = rd_sel_r;
    wr_cnt_nxt_s    = wr_cnt_r;
    rd_cnt_nxt_s    = rd_cnt_r;
    rd_active_nxt_s = rd_active_r;
    data_nxt_s      = data_r;
    underflow_set_s = 1'b0;
    if (frame_start_i) begin
      bank_full_nxt_s = 2'b00;
      wr_sel_nxt_s    = 1'b0;
      rd_sel_nxt_s    = 1'b0;
      wr_cnt_nxt_s    = CNT_ZERO;
      rd_cnt_nxt_s    = CNT_ZERO;
      rd_active_nxt_s = 1'b0;
      data_nxt_s      = 12'h000;
    end else begin
      if (wr_fire_s) begin
        if (wr_last_s) begin
          bank_full_nxt_s[wr_sel_r] = 1'b1;
          wr_cnt_nxt_s              = CNT_ZERO;
          wr_sel_nxt_s              = ~wr_sel_r;
        end else begin
          wr_cnt_nxt_s = wr_cnt_r + CNT_ONE;
        end
      end else begin
        wr_cnt_nxt_s = wr_cnt_r;
      end

      if (data_req_i) begin
        if (rd_last_s) begin
          rd_cnt_nxt_s = CNT_ZERO;
        end else begin
          rd_cnt_nxt_s = rd_cnt_r + CNT_ONE;
        end
        if (test_mode_s) begin
          data_nxt_s = bar_pix_s;
        end else begin
          if (rd_cnt_r == CNT_ZERO) begin
            rd_active_nxt_s = bank_full_r[rd_sel_r];
          end else begin
            rd_active_nxt_s = rd_active_r;
          end
          if (rd_cur_active_s) begin
            data_nxt_s = rd_pix_s;
            if (rd_last_s) begin
              bank_full_nxt_s[rd_sel_r] = 1'b0;
              rd_sel_nxt_s              = ~rd_sel_r;
            end else begin
              rd_sel_nxt_s = rd_sel_r;
            end
          end else begin
            data_nxt_s      = UNDERFLOW_RGB;
            underflow_set_s = 1'b1;
          end
        end
      end else begin
        data_nxt_s = data_r;
      end
    end
  end

  // Sticky underflow: a new underflow beats a simultaneous clear; flushes leave it alone.
  always_comb begin
    underflow_nxt_s = underflow_r;
    if (underflow_set_s) begin
      underflow_nxt_s = 1'b1;
    end else if (underflow_clr_i) begin
      underflow_nxt_s = 1'b0;
    end else begin
      underflow_nxt_s = underflow_r;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full_r <= 2'b00;
      wr_sel_r    <= 1'b0;
      rd_sel_r    <= 1'b0;
      wr_cnt_r    <= CNT_ZERO;
      rd_cnt_r    <= CNT_ZERO;
      rd_active_r <= 1'b0;
      data_r      <= 12'h000;
      underflow_r <= 1'b0;
    end else begin
      bank_full_r <= bank_full_nxt_s;
      wr_sel_r    <= wr_sel_nxt_s;
      rd_sel_r    <= rd_sel_nxt_s;
      wr_cnt_r    <= wr_cnt_nxt_s;
      rd_cnt_r    <= rd_cnt_nxt_s;
      rd_active_r <= rd_active_nxt_s;
      data_r      <= data_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Line storage; no reset, contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_fire_s && !wr_sel_r) begin
      bank0_mem_r[wr_cnt_r] <= pix_data_i;
    end
    if (wr_fire_s && wr_sel_r) begin
      bank1_mem_r[wr_cnt_r] <= pix_data_i;
    end
  end

  assign pix_ready_o = pix_ready_s;
  assign data_o      = data_r;
  assign bank_full_o = bank_full_r;
  assign underflow_o = underflow_r;

endmodule

// File: tb/tb_vga_line_buf.sv
// Self-checking bench for vga_line_buf: a line-queue model checked every cycle,
// plus hand-computed expectations along the directed scenarios.
module tb_vga_line_buf;

  localparam int          AW  = 10;
  localparam logic [11:0] UFC = 12'h000;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] line_len;
  logic          frame_start;
  logic          pix_valid;
  logic [11:0]   pix_data;
  logic          pix_ready;
  logic          data_req;
  logic [11:0]   data_o;
  logic [1:0]    bank_full;
  logic          underflow;
  logic          underflow_clr;
  logic          test_mode = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  vga_line_buf #(.MAX_LINE(1024), .AW(AW), .UNDERFLOW_RGB(UFC), .BAR_SHIFT(1)) dut (
    .clk(clk), .reset(reset), .line_len_i(line_len), .frame_start_i(frame_start),
    .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pix_ready),
    .data_req_i(data_req), .data_o(data_o), .bank_full_o(bank_full),
    .underflow_o(underflow), .underflow_clr_i(underflow_clr)
`ifdef VGA_LINE_BUF_TESTPAT_EN
    , .test_mode_i(test_mode)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: completed lines as a pixel queue ----------------
  logic [11:0] done_q[$];
  logic [11:0] fill_q[$];
  int          m_pos;
  bit          m_act;
  bit          m_rbank;
  logic [11:0] m_data;
  bit          m_uf;
  int          m_len;
  int          m_nl;
  bit          m_set;
  bit          m_pop;
  bit          m_cur;

  function automatic logic [11:0] bars(input int pos);
    int k;
    k = (pos / 2) % 8;
    return ((k & 1) != 0 ? 12'h00F : 12'h000) | ((k & 2) != 0 ? 12'h0F0 : 12'h000) |
           ((k & 4) != 0 ? 12'hF00 : 12'h000);
  endfunction

  function automatic int lines_held();
    return done_q.size() / m_len;
  endfunction

  always @(posedge clk) begin
    m_len = int'(line_len);
    if (reset || frame_start) begin
      done_q.delete();
      fill_q.delete();
      m_pos = 0; m_act = 1'b0; m_rbank = 1'b0; m_data = 12'h000;
      if (reset) m_uf = 1'b0;
      else if (underflow_clr) m_uf = 1'b0;
    end else begin
      m_nl  = lines_held();
      m_set = 1'b0;
      m_pop = 1'b0;
      if (data_req) begin
        if (test_mode) begin
          m_data = bars(m_pos);
        end else begin
          m_cur = (m_pos == 0) ? (m_nl > 0) : m_act;
          if (m_pos == 0) m_act = m_cur;
          if (m_cur) m_data = done_q[m_pos];
          else begin m_data = UFC; m_set = 1'b1; end
          m_pop = m_cur && (m_pos == m_len - 1);
        end
        m_pos = (m_pos == m_len - 1) ? 0 : m_pos + 1;
      end
      if (pix_valid && m_nl < 2) begin
        fill_q.push_back(pix_data);
        if (fill_q.size() == m_len) begin
          foreach (fill_q[j]) done_q.push_back(fill_q[j]);
          fill_q.delete();
        end
      end
      if (m_pop) begin
        for (int j = 0; j < m_len; j++) void'(done_q.pop_front());
        m_rbank = ~m_rbank;
      end
      if (m_set) m_uf = 1'b1;
      else if (underflow_clr) m_uf = 1'b0;
    end
  end

  function automatic logic [1:0] exp_full();
    int n;
    n = lines_held();
    if (n >= 2) return 2'b11;
    if (n == 1) return m_rbank ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_o", {20'd0, data_o}, {20'd0, m_data});
      chk("bank_full", {30'd0, bank_full}, {30'd0, exp_full()});
      chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
      chk("pix_ready", {31'd0, pix_ready}, {31'd0, (lines_held() < 2) && !reset});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1; pix_data = base + 12'(i);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic flush(input int len);
    frame_start = 1'b1; line_len = AW'(len);
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; line_len = 10'd4; frame_start = 1'b0; pix_valid = 1'b0;
    pix_data = 12'h000; data_req = 1'b0; underflow_clr = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("reset_ready", {31'd0, pix_ready}, 32'd0);
    chk("reset_data", {20'd0, data_o}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("ready_after_reset", {31'd0, pix_ready}, 32'd1);

    // Two lines fill both banks.
    push_line(12'h001, 8);
    chk("full_both", {30'd0, bank_full}, 32'd3);
    chk("ready_low", {31'd0, pix_ready}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      data_req = 1'b1; tick();
      chk("line0_pix", {20'd0, data_o}, 32'(i + 1));
    end
    data_req = 1'b0;
    chk("bank0_released", {30'd0, bank_full}, 32'd2);
    chk("ready_rises", {31'd0, pix_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      data_req = 1'b1; tick();
      chk("line1_pix", {20'd0, data_o}, 32'(i + 5));
    end
    data_req = 1'b0;
    chk("all_empty", {30'd0, bank_full}, 32'd0);

    // Underflow on an empty buffer.
    data_req = 1'b1;
    repeat (4) tick();
    data_req = 1'b0;
    chk("uf_data", {20'd0, data_o}, 32'h0);
    chk("uf_set", {31'd0, underflow}, 32'd1);

    // A good line does not clear the sticky flag; the clear does.
    push_line(12'h0A0, 4);
    data_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("good_pix", {20'd0, data_o}, 32'(12'h0A0 + i));
    end
    data_req = 1'b0;
    chk("uf_sticky", {31'd0, underflow}, 32'd1);
    underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
    chk("uf_cleared", {31'd0, underflow}, 32'd0);

    // Bank becomes full at rd_cnt == 2: rest of this line underflows.
    data_req = 1'b1; repeat (2) tick(); data_req = 1'b0;
    push_line(12'h300, 4);
    data_req = 1'b1;
    repeat (2) begin
      tick();
      chk("midline_uf", {20'd0, data_o}, 32'h0);
    end
    tick();
    chk("next_line_pix0", {20'd0, data_o}, 32'h300);
    repeat (3) tick();
    chk("next_line_pix3", {20'd0, data_o}, 32'h303);
    data_req = 1'b0;

    // Flush mid-line with both banks full.
    push_line(12'h400, 8);
    data_req = 1'b1; repeat (2) tick(); data_req = 1'b0;
    chk("pre_flush_pix", {20'd0, data_o}, 32'h401);
    flush(4);
    chk("flush_full", {30'd0, bank_full}, 32'd0);
    chk("flush_ready", {31'd0, pix_ready}, 32'd1);
    chk("flush_keeps_uf", {31'd0, underflow}, 32'd1);
    data_req = 1'b1; tick(); data_req = 1'b0;
    chk("post_flush_uf", {20'd0, data_o}, 32'h0);

    // Single-pixel lines.
    flush(1);
    push_line(12'h555, 2);
    data_req = 1'b1;
    tick(); chk("len1_a", {20'd0, data_o}, 32'h555);
    tick(); chk("len1_b", {20'd0, data_o}, 32'h556);
    tick(); chk("len1_uf", {20'd0, data_o}, 32'h0);
    data_req = 1'b0;

    // Overlapping write/read traffic, clears and a reset in the middle.
    flush(5);
    for (int i = 0; i < 300; i++) begin
      pix_valid     = (i % 3) != 0;
      pix_data      = 12'(i) ^ 12'h5A5;
      data_req      = (i % 4) != 3;
      underflow_clr = (i % 23) == 0;
      reset         = (i == 150);
      tick();
    end
    pix_valid = 1'b0; data_req = 1'b0; underflow_clr = 1'b0; reset = 1'b0;
    tick();

`ifdef VGA_LINE_BUF_TESTPAT_EN
    flush(16);
    push_line(12'h100, 16);
    test_mode = 1'b1;
    begin
      logic [11:0] exp_bars [16];
      exp_bars = '{12'h000, 12'h000, 12'h00F, 12'h00F, 12'h0F0, 12'h0F0, 12'h0FF, 12'h0FF,
                   12'hF00, 12'hF00, 12'hF0F, 12'hF0F, 12'hFF0, 12'hFF0, 12'hFFF, 12'hFFF};
      data_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
        tick();
        chk("bars", {20'd0, data_o}, {20'd0, exp_bars[i]});
      end
      data_req = 1'b0;
    end
    test_mode = 1'b0;
    chk("bars_bank_kept", {30'd0, bank_full}, 32'd1);
    tick();
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/vga_line_buf.md
Name: vga_line_buf

Overview:
- Ping-pong line buffer directly upstream of the VGA timing controller.
- Accepts 12-bit pixels from the frame-fetch stream (valid/ready) into one line bank while the other bank is drained one pixel per cycle on the controller's data request.
- The output pixel is registered, so it arrives in the same cycle the controller's registered blank flag rises.
- Detects and flags underflow without ever losing line alignment.

Parameters:
- MAX_LINE, 1024: depth of each bank in pixels; must be ≥ the largest line_len_i.
- AW, 10: address/counter width; MAX_LINE ≤ 2^AW.
- UNDERFLOW_RGB, 12'h000: pixel value driven when a requested pixel has no valid line.
- BAR_SHIFT, 6: test-pattern bar width is 2^BAR_SHIFT pixels (used only with the optional feature).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- line_len_i  in  AW  active pixels per line (1..MAX_LINE); held static during a frame
- frame_start_i  in  1  one-cycle pulse; flushes the buffer at frame start
- pix_valid_i  in  1  upstream pixel valid
- pix_data_i  in  12  upstream pixel {B[11:8], G[7:4], R[3:0]}
- pix_ready_o  out  1  buffer can accept a pixel this cycle
- data_req_i  in  1  pixel request from the timing controller (combinational on its side)
- data_o  out  12  registered pixel to the timing controller
- bank_full_o  out  2  per-bank FULL status
- underflow_o  out  1  sticky underflow flag
- underflow_clr_i  in  1  clears underflow_o
- test_mode_i  in  1  present only with VGA_LINE_BUF_TESTPAT_EN

Behaviour:
- Reset and one cycle after frame_start_i:
  - both banks EMPTY; wr_sel = rd_sel = 0; wr_cnt = rd_cnt = 0; rd_active = 0.
  - data_o = 0, pix_ready_o = 0 during the reset cycle, underflow_o = 0.
  - frame_start_i does not clear underflow_o.
- Priority: reset > frame_start_i > normal operation. A transfer offered in a reset or flush cycle is discarded.
- Per-bank state is EMPTY or FULL. There is no partial-full state; fill progress lives in wr_cnt.
- Write side:
  - pix_ready_o = (bank[wr_sel] == EMPTY) and not reset.
  - A transfer occurs when valid & ready: mem[wr_sel][wr_cnt] <= pix_data_i, wr_cnt++.
  - On the transfer with wr_cnt == line_len_i-1: bank[wr_sel] <= FULL, wr_cnt <= 0, wr_sel toggles.
- Read side, evaluated on each data_req_i:
  - Line start (rd_cnt == 0): rd_active <= (bank[rd_sel] == FULL).
  - The decision for the current request uses the combinational value (rd_cnt == 0 ? bank[rd_sel] == FULL : rd_active).
  - If active: data_o <= mem[rd_sel][rd_cnt] on the next clock edge (latency 1).
  - If not active: data_o <= UNDERFLOW_RGB and underflow_o <= 1.
  - rd_cnt++ on every request, active or not.
  - On the request with rd_cnt == line_len_i-1: rd_cnt <= 0. If active, bank[rd_sel] <= EMPTY and rd_sel toggles; if inactive, no bank change.
  - A bank that becomes FULL mid-line is never read mid-line; it waits for the next line start.
- No request: data_o holds its last value.
- Simultaneous events:
  - Write completing bank X and read releasing bank Y in the same cycle: both updates apply.
  - The same bank cannot be both FULL-completing and EMPTY-releasing in one cycle.
  - underflow_clr_i and a new underflow in the same cycle: the set wins.
- Width: wr_cnt and rd_cnt are AW bits. line_len_i == 0 is illegal; behaviour is undefined.

Optional Feature:
- Macro: VGA_LINE_BUF_TESTPAT_EN
- Defined: adds the test_mode_i port. While test_mode_i = 1, requests do not consume banks or set underflow. On each request:
  - data_o <= color bars with bar index k = rd_cnt[BAR_SHIFT+2:BAR_SHIFT].
  - R = {4{k[0]}}, G = {4{k[1]}}, B = {4{k[2]}}.
  - rd_cnt still counts and wraps at line_len_i.
  - The write side is unaffected.
- Undefined: the port is absent and the block operates in normal mode only.

Test Plan:
- Reset, line_len_i=4, stream 8 pixels 12'h001..12'h008 -> pix_ready_o drops after 8 accepts; bank_full_o=2'b11.
- Then 4 data_req_i cycles -> data_o = 001, 002, 003, 004 each one cycle after its request; bank_full_o=2'b10; pix_ready_o rises the cycle after the 4th request.
- Empty buffer, 4 requests -> data_o=000 ×4, underflow_o=1.
- Then fill one line and request 4 -> correct data, underflow_o stays 1 until underflow_clr_i.
- Bank FULL arrives at rd_cnt=2 of a 4-pixel line -> remaining 2 requests output UNDERFLOW_RGB; the next line reads the full bank from pixel 0.
- frame_start_i mid-line with both banks full -> next cycle bank_full_o=0, pix_ready_o=1, next request outputs UNDERFLOW_RGB.
- With VGA_LINE_BUF_TESTPAT_EN, BAR_SHIFT=1, test_mode_i=1, 16 requests -> data_o sequence 000,000,00F,00F,0F0,0F0,0FF,0FF,F00,F00,F0F,F0F,FF0,FF0,FFF,FFF; bank_full_o unchanged.
